// File: rtl/count_wrap_monitor_if.sv
// Bus between the up/down counter and count_wrap_monitor: sample qualifier,
// counter value and the monitor's registered status.
interface count_wrap_monitor_if #(
  parameter int WIDTH  = 3,
  parameter int WRAP_W = 8
);
  logic              en;
  logic [WIDTH-1:0]  cnt_in;
  logic              dir_up;
  logic              dir_valid;
  logic              ovf_pulse;
  logic              unf_pulse;
  logic [WRAP_W-1:0] wrap_count;
  logic              err;
  logic              stall;

  modport master (
    output en, cnt_in,
    input  dir_up, dir_valid, ovf_pulse, unf_pulse, wrap_count, err, stall
  );

  modport slave (
    input  en, cnt_in,
    output dir_up, dir_valid, ovf_pulse, unf_pulse, wrap_count, err, stall
  );
endinterface

// File: rtl/count_wrap_monitor.sv
// Watches an up/down counter: infers direction, flags wraps and illegal jumps.
// Optional stall detector enabled by defining CWM_STALL_DETECT_EN.
module count_wrap_monitor #(
  parameter int WIDTH       = 3,
  parameter int WRAP_W      = 8,
  parameter int STALL_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  count_wrap_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    STEP_UP   = 2'd0,
    STEP_DOWN = 2'd1,
    STEP_HOLD = 2'd2,
    STEP_JUMP = 2'd3
  } step_t;

  localparam logic [WIDTH-1:0]  CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]  CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};

  if (WIDTH < 2 || STALL_LIMIT < 1) begin : g_bad_cfg
    $error("count_wrap_monitor: WIDTH must be >= 2 and STALL_LIMIT >= 1");
  end

  function automatic step_t classify_step(input logic [WIDTH-1:0] delta);
    if (delta == WIDTH'(1)) begin
      classify_step = STEP_UP;
    end else if (delta == CNT_MAX) begin
      classify_step = STEP_DOWN;
    end else if (delta == CNT_ZERO) begin
      classify_step = STEP_HOLD;
    end else begin
      classify_step = STEP_JUMP;
    end
  endfunction

  state_t            state_r, state_nxt_s;
  logic [WIDTH-1:0]  prev_r, prev_nxt_s;
  logic              dir_up_r, dir_up_nxt_s;
  logic              dir_valid_r, dir_valid_nxt_s;
  logic              ovf_r, ovf_nxt_s;
  logic              unf_r, unf_nxt_s;
  logic [WRAP_W-1:0] wrap_r, wrap_nxt_s, wrap_inc_s;
  logic              err_r, err_nxt_s;
  logic [WIDTH-1:0]  delta_s;
  step_t             step_s;
  logic              hold_s;

  assign delta_s    = bus.cnt_in - prev_r;
  assign step_s     = classify_step(delta_s);
  assign wrap_inc_s = (wrap_r == WRAP_MAX) ? wrap_r : wrap_r + WRAP_W'(1);
  // The first sample after reset has no predecessor, so it never counts as HOLD.
  assign hold_s     = bus.en && (state_r != S_INIT) && (step_s == STEP_HOLD);

  // Next-state and next-output decode for the direction/wrap FSM.
  always_comb begin
    state_nxt_s     = state_r;
    prev_nxt_s      = prev_r;
    dir_up_nxt_s    = dir_up_r;
    dir_valid_nxt_s = dir_valid_r;
    ovf_nxt_s       = 1'b0;
    unf_nxt_s       = 1'b0;
    wrap_nxt_s      = wrap_r;
    err_nxt_s       = err_r;
    if (bus.en) begin
      prev_nxt_s = bus.cnt_in;
      case (state_r)
        S_INIT: begin
          state_nxt_s = S_UP;
        end
        S_UP, S_DOWN: begin
          case (step_s)
            STEP_UP: begin
              state_nxt_s     = S_UP;
              dir_up_nxt_s    = 1'b1;
              dir_valid_nxt_s = 1'b1;
              if (prev_r == CNT_MAX) begin
                ovf_nxt_s  = 1'b1;
                wrap_nxt_s = wrap_inc_s;
              end else begin
                ovf_nxt_s  = 1'b0;
              end
            end
            STEP_DOWN: begin
              state_nxt_s     = S_DOWN;
              dir_up_nxt_s    = 1'b0;
              dir_valid_nxt_s = 1'b1;
              if (prev_r == CNT_ZERO) begin
                unf_nxt_s  = 1'b1;
                wrap_nxt_s = wrap_inc_s;
              end else begin
                unf_nxt_s  = 1'b0;
              end
            end
            STEP_HOLD: begin
              state_nxt_s = state_r;
            end
            STEP_JUMP: begin
              state_nxt_s = S_ERR;
              err_nxt_s   = 1'b1;
            end
            default: begin
              state_nxt_s = S_ERR;
              err_nxt_s   = 1'b1;
            end
          endcase
        end
        S_ERR: begin
          err_nxt_s = 1'b1;
        end
        default: begin
          state_nxt_s = S_ERR;
          err_nxt_s   = 1'b1;
        end
      endcase
    end else begin
      prev_nxt_s = prev_r;
    end
  end

  // State and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_INIT;
      prev_r      <= CNT_ZERO;
      dir_up_r    <= 1'b0;
      dir_valid_r <= 1'b0;
      ovf_r       <= 1'b0;
      unf_r       <= 1'b0;
      wrap_r      <= {WRAP_W{1'b0}};
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      prev_r      <= prev_nxt_s;
      dir_up_r    <= dir_up_nxt_s;
      dir_valid_r <= dir_valid_nxt_s;
      ovf_r       <= ovf_nxt_s;
      unf_r       <= unf_nxt_s;
      wrap_r      <= wrap_nxt_s;
      err_r       <= err_nxt_s;
    end
  end

  assign bus.dir_up     = dir_up_r;
  assign bus.dir_valid  = dir_valid_r;
  assign bus.ovf_pulse  = ovf_r;
  assign bus.unf_pulse  = unf_r;
  assign bus.wrap_count = wrap_r;
  assign bus.err        = err_r;

`ifdef CWM_STALL_DETECT_EN
  localparam int SCW = $clog2(STALL_LIMIT + 1);
  localparam logic [SCW-1:0] STALL_LIM = SCW'(STALL_LIMIT);

  logic [SCW-1:0] stall_cnt_r, stall_cnt_nxt_s;
  logic           stall_r;

  // Saturating run-length of enabled HOLD samples.
  always_comb begin
    stall_cnt_nxt_s = stall_cnt_r;
    if (!bus.en) begin
      stall_cnt_nxt_s = stall_cnt_r;
    end else if (hold_s) begin
      stall_cnt_nxt_s = (stall_cnt_r >= STALL_LIM) ? STALL_LIM : stall_cnt_r + SCW'(1);
    end else begin
      stall_cnt_nxt_s = {SCW{1'b0}};
    end
  end

  // Stall counter and registered stall flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= {SCW{1'b0}};
      stall_r     <= 1'b0;
    end else begin
      stall_cnt_r <= stall_cnt_nxt_s;
      stall_r     <= (stall_cnt_nxt_s >= STALL_LIM);
    end
  end

  assign bus.stall = stall_r;
`else
  logic unused_hold_s;
  assign unused_hold_s = hold_s;
  assign bus.stall     = 1'b0;
`endif

endmodule

// File: tb/tb_count_wrap_monitor.sv
// Scoreboard bench for count_wrap_monitor: two instances (WRAP_W=8 and WRAP_W=2)
// share stimulus; a behavioural model pushes expected status per sample.
module tb_count_wrap_monitor;
  localparam int WIDTH = 3;
  localparam int MAXV  = 7;
  localparam int SLIM  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  count_wrap_monitor_if #(.WIDTH(WIDTH), .WRAP_W(8)) bus8 ();
  count_wrap_monitor_if #(.WIDTH(WIDTH), .WRAP_W(2)) bus2 ();

  count_wrap_monitor #(.WIDTH(WIDTH), .WRAP_W(8), .STALL_LIMIT(SLIM)) u_dut8 (
    .clk(clk), .rst(rst), .bus(bus8.slave));
  count_wrap_monitor #(.WIDTH(WIDTH), .WRAP_W(2), .STALL_LIMIT(SLIM)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave));

  typedef struct {
    int dir_up; int dir_valid; int ovf; int unf;
    int wrap8; int wrap2; int err; int stall;
  } exp_t;

  exp_t sb_q[$];
  int checks   = 0;
  int failures = 0;

  // model state: 0 = init, 1 = running, 2 = error
  int m_state, m_prev, m_dir_up, m_valid, m_ovf, m_unf;
  int m_wrap8, m_wrap2, m_err, m_stall_cnt;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic compare_all(input string tag, input exp_t e);
    check_val({tag, ".dir_up"},    int'(bus8.dir_up),     e.dir_up);
    check_val({tag, ".dir_valid"}, int'(bus8.dir_valid),  e.dir_valid);
    check_val({tag, ".ovf"},       int'(bus8.ovf_pulse),  e.ovf);
    check_val({tag, ".unf"},       int'(bus8.unf_pulse),  e.unf);
    check_val({tag, ".wrap8"},     int'(bus8.wrap_count), e.wrap8);
    check_val({tag, ".err"},       int'(bus8.err),        e.err);
    check_val({tag, ".stall"},     int'(bus8.stall),      e.stall);
    check_val({tag, ".wrap2"},     int'(bus2.wrap_count), e.wrap2);
    check_val({tag, ".ovf2"},      int'(bus2.ovf_pulse),  e.ovf);
    check_val({tag, ".err2"},      int'(bus2.err),        e.err);
  endtask

  task automatic model_reset();
    m_state = 0; m_prev = 0; m_dir_up = 0; m_valid = 0; m_ovf = 0; m_unf = 0;
    m_wrap8 = 0; m_wrap2 = 0; m_err = 0; m_stall_cnt = 0;
  endtask

  function automatic exp_t model_snapshot();
    exp_t e;
    e.dir_up = m_dir_up; e.dir_valid = m_valid; e.ovf = m_ovf; e.unf = m_unf;
    e.wrap8 = m_wrap8; e.wrap2 = m_wrap2; e.err = m_err;
`ifdef CWM_STALL_DETECT_EN
    e.stall = (m_stall_cnt >= SLIM) ? 1 : 0;
`else
    e.stall = 0;
`endif
    return e;
  endfunction

  task automatic model_step(input int e, input int v);
    int d;
    int hold;
    m_ovf = 0;
    m_unf = 0;
    hold  = 0;
    if (e != 0) begin
      if (m_state == 0) begin
        m_state = 1;
      end else begin
        d = (v - m_prev + 8) % 8;
        hold = (d == 0) ? 1 : 0;
        if (m_state == 1) begin
          if (d == 1) begin
            m_dir_up = 1; m_valid = 1;
            if (m_prev == MAXV) begin
              m_ovf = 1;
              if (m_wrap8 < 255) m_wrap8++;
              if (m_wrap2 < 3) m_wrap2++;
            end
          end else if (d == MAXV) begin
            m_dir_up = 0; m_valid = 1;
            if (m_prev == 0) begin
              m_unf = 1;
              if (m_wrap8 < 255) m_wrap8++;
              if (m_wrap2 < 3) m_wrap2++;
            end
          end else if (d != 0) begin
            m_state = 2;
            m_err   = 1;
          end
        end
      end
      if (hold != 0) begin
        if (m_stall_cnt < SLIM) m_stall_cnt++;
      end else begin
        m_stall_cnt = 0;
      end
      m_prev = v;
    end
  endtask

  // Drive one sample just after a falling edge, then check on the next falling edge.
  task automatic sample(input string tag, input int e, input int v);
    exp_t got_e;
    bus8.en     = (e != 0);
    bus2.en     = (e != 0);
    bus8.cnt_in = v[WIDTH-1:0];
    bus2.cnt_in = v[WIDTH-1:0];
    model_step(e, v);
    sb_q.push_back(model_snapshot());
    @(posedge clk);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check_val({tag, ".sb_empty"}, 0, 1);
    end else begin
      got_e = sb_q.pop_front();
      compare_all(tag, got_e);
    end
  endtask

  initial begin
    int v;
    int seq_count[] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
    int seq_down[]  = '{2, 1, 0, 7, 6, 7, 0};
    int seq_jump[]  = '{2, 5, 5, 6, 7, 0, 1};
    int seq_rest[]  = '{3, 3, 3, 3, 3, 4, 5};

    rst = 1'b1;
    bus8.en = 1'b0; bus2.en = 1'b0;
    bus8.cnt_in = 3'd0; bus2.cnt_in = 3'd0;
    model_reset();
    #12;
    compare_all("reset", model_snapshot());
    @(negedge clk);
    rst = 1'b0;

    foreach (seq_count[i]) sample("count", 1, seq_count[i]);
    foreach (seq_down[i])  sample("down", 1, seq_down[i]);
    sample("gate", 0, 3);
    sample("gate", 0, 4);
    sample("gate", 0, 3);
    for (int i = 0; i < 5; i++) sample("hold", 1, 0);
    sample("unhold", 1, 1);

    v = 1;
    for (int i = 0; i < 40; i++) begin
      v = (v + 1) % 8;
      sample("sat", 1, v);
    end

    foreach (seq_jump[i]) sample("jump", 1, seq_jump[i]);

    // Reset asserted between clock edges must clear outputs at once.
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    compare_all("async_rst", model_snapshot());
    @(negedge clk);
    rst = 1'b0;

    foreach (seq_rest[i]) sample("restart", 1, seq_rest[i]);

    if (sb_q.size() != 0) check_val("sb_leftover", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
